axis_dac_stream_buffer: RTL and testbench

Parametrised multi-channel DAC streaming front-end with an elastic FIFO, prefill/underrun control and selectable output code format. It sits between the AXI-Stream sample source (OFDM modulator / DMA) and the vendor-specific DAC pin driver. It presents one registered parallel code per channel per aclk cycle, and replaces the free-running, unbuffered DAC path with a controlled start and deterministic starvation behaviour.

---
 rtl/axis_dac_stream_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_axis_dac_stream_buffer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dac_stream_buffer.sv
// axis_dac_stream_buffer
// AXI-Stream to parallel multi-channel DAC front-end. Samples are buffered in
// an elastic FIFO, released only after a prefill threshold is reached, and
// converted to the DAC code format latched when streaming was enabled. FIFO
// starvation drops back to prefill with a deterministic output code.
module axis_dac_stream_buffer #(
  parameter int NUM_CH          = 2,
  parameter int DAC_DATA_WIDTH  = 14,
  parameter int LANE_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 5,
  parameter int PREFILL_LEVEL   = 16,
  parameter int DEFAULT_FORMAT  = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                cfg_enable,
  input  logic [1:0]                          cfg_format,
  input  logic                                cfg_hold_last,
  input  logic [NUM_CH*LANE_WIDTH-1:0]        s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [NUM_CH*DAC_DATA_WIDTH-1:0]    dac_dat,
  output logic                                dac_valid,
  output logic                                dac_rst,
  output logic                                debug_trigger,
  output logic [15:0]                         underrun_cnt,
  output logic [FIFO_ADDR_WIDTH:0]            fifo_level
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW    = FIFO_ADDR_WIDTH + 1;
  localparam int DW    = NUM_CH * DAC_DATA_WIDTH;

  localparam logic [LW-1:0] DEPTH_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_THR = LW'(PREFILL_LEVEL);
  localparam logic [1:0]    RST_FMT     = 2'(DEFAULT_FORMAT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Code conversion for one channel; format 3 behaves like plain pass-through.
  function automatic logic [DAC_DATA_WIDTH-1:0] conv_code(
    input logic [DAC_DATA_WIDTH-1:0] x,
    input logic [1:0]                fmt
  );
    logic [DAC_DATA_WIDTH-1:0] r;
    case (fmt)
      2'd1:    r = {~x[DAC_DATA_WIDTH-1], x[DAC_DATA_WIDTH-2:0]};
      2'd2:    r = {x[DAC_DATA_WIDTH-1], ~x[DAC_DATA_WIDTH-2:0]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Applies the conversion to every channel of a packed FIFO word.
  function automatic logic [DW-1:0] conv_word(
    input logic [DW-1:0] w,
    input logic [1:0]    fmt
  );
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      r[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = conv_code(w[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH], fmt);
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]            fmt_q, fmt_d;
  logic [DW-1:0]         dac_dat_q, dac_dat_d;
  logic [DW-1:0]         last_code_q, last_code_d;
  logic                  dac_valid_q, dac_valid_d;
  logic                  dac_rst_q, dac_rst_d;
  logic                  trigger_q, trigger_d;
  logic                  seen_q, seen_d;
  logic [15:0]           underrun_q, underrun_d;
  logic [DW-1:0]         mem_q [DEPTH];

  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DW-1:0]         push_word;
  logic [DW-1:0]         pop_code;
  logic [DW-1:0]         hold_code;
  logic [DW-1:0]         rst_idle;
  logic                  unused_tdata;

  // Upper lane bits carry no DAC information; fold them away explicitly.
  assign unused_tdata = ^s_axis_tdata;

  assign rst_idle  = conv_word('0, RST_FMT);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == DEPTH_LVL);
  assign empty     = (level == '0);

  assign s_axis_tready = (state_q != ST_IDLE) && !full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = (state_q == ST_RUN) && cfg_enable && !empty;
  assign pop_code      = conv_word(mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]], fmt_q);
  assign hold_code     = (cfg_hold_last && seen_q) ? last_code_q : conv_word('0, fmt_q);

  // Extract the DAC-width slice of each channel lane into one packed word.
  always_comb begin
    push_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push_word[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] = s_axis_tdata[k*LANE_WIDTH +: DAC_DATA_WIDTH];
    end
  end

  // FIFO storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= push_word;
    end
  end

  // Next-state, FIFO pointer and registered-output computation.
  always_comb begin
    state_d     = state_q;
    fmt_d       = fmt_q;
    wr_ptr_d    = push ? (wr_ptr_q + LW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop ? (rd_ptr_q + LW'(1)) : rd_ptr_q;
    dac_dat_d   = hold_code;
    dac_valid_d = 1'b0;
    trigger_d   = 1'b0;
    seen_d      = seen_q;
    last_code_d = last_code_q;
    underrun_d  = underrun_q;

    if (!cfg_enable) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      seen_d    = 1'b0;
      dac_dat_d = conv_word('0, fmt_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          fmt_d     = cfg_format;
          state_d   = ST_PREFILL;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          seen_d    = 1'b0;
          dac_dat_d = conv_word('0, cfg_format);
        end
        ST_PREFILL: begin
          if (level >= PREFILL_THR) begin
            state_d   = ST_RUN;
            trigger_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (!empty) begin
            dac_dat_d   = pop_code;
            dac_valid_d = 1'b1;
            last_code_d = pop_code;
            seen_d      = 1'b1;
          end else begin
            state_d = ST_PREFILL;
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      endcase
    end

    dac_rst_d = (state_d == ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      fmt_q       <= RST_FMT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dac_dat_q   <= rst_idle;
      last_code_q <= rst_idle;
      dac_valid_q <= 1'b0;
      dac_rst_q   <= 1'b1;
      trigger_q   <= 1'b0;
      seen_q      <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dac_dat_q   <= dac_dat_d;
      last_code_q <= last_code_d;
      dac_valid_q <= dac_valid_d;
      dac_rst_q   <= dac_rst_d;
      trigger_q   <= trigger_d;
      seen_q      <= seen_d;
      underrun_q  <= underrun_d;
    end
  end

  assign dac_dat       = dac_dat_q;
  assign dac_valid     = dac_valid_q;
  assign dac_rst       = dac_rst_q;
  assign debug_trigger = trigger_q;
  assign underrun_cnt  = underrun_q;
  assign fifo_level    = level;

endmodule

// File: tb/tb_axis_dac_stream_buffer.sv
// Testbench for axis_dac_stream_buffer: randomized AXI-Stream traffic checked
// against a queue-based behavioural model, plus fixed-value checks for reset,
// formats, starvation, back-pressure and disable behaviour.
module tb_axis_dac_stream_buffer;

  localparam int DEPTH = 32;
  localparam int PRE   = 16;

  logic        aclk;
  logic        aresetn;
  logic        cfg_enable;
  logic [1:0]  cfg_format;
  logic        cfg_hold_last;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [27:0] dac_dat;
  logic        dac_valid;
  logic        dac_rst;
  logic        debug_trigger;
  logic [15:0] underrun_cnt;
  logic [5:0]  fifo_level;

  logic        d2_tready;
  logic [27:0] d2_dat;
  logic        d2_valid;
  logic        d2_rst;
  logic        d2_trig;
  logic [15:0] d2_under;
  logic [5:0]  d2_level;

  int total;
  int bad;

  axis_dac_stream_buffer dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_format(cfg_format),
    .cfg_hold_last(cfg_hold_last), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .dac_dat(dac_dat), .dac_valid(dac_valid), .dac_rst(dac_rst),
    .debug_trigger(debug_trigger), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  // Second instance whose prefill threshold equals the FIFO depth
  axis_dac_stream_buffer #(.PREFILL_LEVEL(32)) dut_full (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable), .cfg_format(cfg_format),
    .cfg_hold_last(cfg_hold_last), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(d2_tready), .dac_dat(d2_dat), .dac_valid(d2_valid), .dac_rst(d2_rst),
    .debug_trigger(d2_trig), .underrun_cnt(d2_under), .fifo_level(d2_level)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- behavioural reference model ----------------
  int          m_state;     // 0 = idle, 1 = prefill, 2 = run
  logic [1:0]  m_fmt;
  bit          m_seen;
  logic [27:0] m_last;
  logic [27:0] fq[$];
  logic [27:0] e_dat;
  bit          e_valid;
  bit          e_rst;
  bit          e_trig;
  int          e_under;
  bit          mr;
  int          msz;
  logic [27:0] mh;
  logic [27:0] minw;

  function automatic logic [13:0] m_conv(input logic [13:0] x, input logic [1:0] f);
    if (f == 2'd1) return 14'((int'(x) + 8192) % 16384);
    if (f == 2'd2) return x ^ 14'h1FFF;
    return x;
  endfunction

  function automatic logic [27:0] m_word(input logic [27:0] w, input logic [1:0] f);
    return {m_conv(w[27:14], f), m_conv(w[13:0], f)};
  endfunction

  function automatic logic [27:0] m_idle(input logic [1:0] f);
    return m_word(28'h0, f);
  endfunction

  function automatic bit m_ready();
    return (m_state != 0) && (fq.size() < DEPTH);
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_state = 0;
      fq.delete();
      m_fmt   = 2'd2;
      m_seen  = 1'b0;
      m_last  = 28'h0;
      e_dat   = m_idle(2'd2);
      e_valid = 1'b0;
      e_rst   = 1'b1;
      e_trig  = 1'b0;
      e_under = 0;
    end else begin
      msz     = fq.size();
      mr      = m_ready();
      minw    = {s_axis_tdata[29:16], s_axis_tdata[13:0]};
      mh      = (cfg_hold_last && m_seen) ? m_last : m_idle(m_fmt);
      e_trig  = 1'b0;
      e_valid = 1'b0;
      if (!cfg_enable) begin
        m_state = 0;
        fq.delete();
        m_seen  = 1'b0;
        e_dat   = m_idle(m_fmt);
      end else if (m_state == 0) begin
        m_fmt   = cfg_format;
        m_state = 1;
        fq.delete();
        m_seen  = 1'b0;
        e_dat   = m_idle(cfg_format);
      end else begin
        if (m_state == 1) begin
          e_dat = mh;
          if (msz >= PRE) begin
            m_state = 2;
            e_trig  = 1'b1;
          end
        end else if (msz > 0) begin
          m_last  = m_word(fq.pop_front(), m_fmt);
          e_dat   = m_last;
          e_valid = 1'b1;
          m_seen  = 1'b1;
        end else begin
          e_dat   = mh;
          m_state = 1;
          if (e_under < 65535) e_under++;
        end
        if (s_axis_tvalid && mr) fq.push_back(minw);
      end
      e_rst = (m_state == 0);
    end
  end

  function automatic logic [53:0] dut_vec();
    return {dac_dat, dac_valid, dac_rst, debug_trigger, underrun_cnt, fifo_level, s_axis_tready};
  endfunction

  function automatic logic [53:0] exp_vec();
    return {e_dat, e_valid, e_rst, e_trig, 16'(e_under), 6'(fq.size()), m_ready()};
  endfunction

  task automatic drive_word(input logic [13:0] ch0, input logic [13:0] ch1);
    s_axis_tdata = {2'($urandom), ch1, 2'($urandom), ch0};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0; cfg_enable = 1'b0; cfg_format = 2'd2; cfg_hold_last = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    repeat (2) @(negedge aclk);
    total++;
    if (dac_dat !== {14'd8191, 14'd8191}) begin
      bad++; $display("[TB] FAIL reset_dat: got %h expected %h", dac_dat, {14'd8191, 14'd8191});
    end
    total++;
    if ({dac_rst, s_axis_tready, dac_valid, debug_trigger} !== 4'b1000) begin
      bad++; $display("[TB] FAIL reset_ctrl: got %b expected 1000", {dac_rst, s_axis_tready, dac_valid, debug_trigger});
    end
    total++;
    if ({underrun_cnt, fifo_level} !== 22'h0) begin
      bad++; $display("[TB] FAIL reset_counts: got %h expected 0", {underrun_cnt, fifo_level});
    end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_prefill_run();
    int  n_push = 0;
    int  trig = 0;
    int  nvalid = 0;
    bit  will_push;
    cfg_format = 2'd2; cfg_hold_last = 1'b0; cfg_enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (n_push < 16) begin
        s_axis_tvalid = 1'b1;
        drive_word(14'(n_push), 14'($urandom));
      end else begin
        s_axis_tvalid = 1'b0;
      end
      will_push = s_axis_tvalid && m_ready();
      @(negedge aclk);
      if (will_push) n_push++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL prefill_vec t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
      end
      if (debug_trigger === 1'b1) trig++;
      if (dac_valid === 1'b1) begin
        total++;
        if (dac_dat[13:0] !== (14'h1FFF ^ 14'(nvalid))) begin
          bad++; $display("[TB] FAIL run_ch0 #%0d: got %h expected %h", nvalid, dac_dat[13:0], 14'h1FFF ^ 14'(nvalid));
        end
        nvalid++;
      end
    end
    total++;
    if (trig != 1) begin
      bad++; $display("[TB] FAIL trigger_pulses: got %0d expected 1", trig);
    end
    total++;
    if (nvalid != 16) begin
      bad++; $display("[TB] FAIL valid_count: got %0d expected 16", nvalid);
    end
    total++;
    if ({underrun_cnt, dac_valid, dac_rst, s_axis_tready} !== {16'd1, 3'b001}) begin
      bad++; $display("[TB] FAIL underrun_state: got %h expected %h", {underrun_cnt, dac_valid, dac_rst, s_axis_tready}, {16'd1, 3'b001});
    end
    total++;
    if (dac_dat !== {14'h1FFF, 14'h1FFF}) begin
      bad++; $display("[TB] FAIL starve_idle: got %h expected %h", dac_dat, {14'h1FFF, 14'h1FFF});
    end
  endtask

  task automatic test_hold_last();
    cfg_hold_last = 1'b1;
    @(negedge aclk);
    total++;
    if (dac_dat[13:0] !== 14'h1FF0) begin
      bad++; $display("[TB] FAIL hold_code: got %h expected 1ff0", dac_dat[13:0]);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("[TB] FAIL hold_vec: got %h expected %h", dut_vec(), exp_vec());
    end
    cfg_hold_last = 1'b0;
    @(negedge aclk);
    total++;
    if (dac_dat !== {14'h1FFF, 14'h1FFF}) begin
      bad++; $display("[TB] FAIL unhold_idle: got %h expected %h", dac_dat, {14'h1FFF, 14'h1FFF});
    end
  endtask

  task automatic test_formats();
    logic [27:0] exp_idle;
    logic [27:0] exp_run;
    int          n_push;
    int          nvalid;
    bit          will_push;
    for (int f = 0; f < 2; f++) begin
      exp_idle = (f == 0) ? 28'h0 : {14'h2000, 14'h2000};
      exp_run  = (f == 0) ? {14'h0000, 14'h2000} : {14'h2000, 14'h0000};
      cfg_enable = 1'b0; s_axis_tvalid = 1'b0;
      @(negedge aclk);
      cfg_format = 2'(f); cfg_enable = 1'b1;
      @(negedge aclk);
      total++;
      if (dac_dat !== exp_idle) begin
        bad++; $display("[TB] FAIL fmt%0d_idle: got %h expected %h", f, dac_dat, exp_idle);
      end
      cfg_format = 2'($urandom);
      n_push = 0; nvalid = 0;
      for (int c = 0; c < 45; c++) begin
        s_axis_tvalid = (n_push < 16);
        drive_word(14'h2000, 14'h0000);
        will_push = s_axis_tvalid && m_ready();
        @(negedge aclk);
        if (will_push) n_push++;
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++; $display("[TB] FAIL fmt%0d_vec t=%0t: got %h expected %h", f, $time, dut_vec(), exp_vec());
        end
        if (dac_valid === 1'b1) begin
          nvalid++;
          total++;
          if (dac_dat !== exp_run) begin
            bad++; $display("[TB] FAIL fmt%0d_code: got %h expected %h", f, dac_dat, exp_run);
          end
        end
      end
      total++;
      if (nvalid != 16) begin
        bad++; $display("[TB] FAIL fmt%0d_count: got %0d expected 16", f, nvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_push = 0;
    int phase = 0;
    int n_hold = 0;
    cfg_enable = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge aclk);
    cfg_enable = 1'b1; cfg_format = 2'($urandom); cfg_hold_last = 1'($urandom);
    for (int c = 0; c < 80; c++) begin
      if (phase == 0 && n_push >= 16 && m_state == 2 && fq.size() == 10) phase = 1;
      if (phase == 1 && n_hold >= 10) phase = 2;
      s_axis_tvalid = (phase == 0 && n_push < 16) || (phase == 1);
      drive_word(14'($urandom), 14'($urandom));
      if (s_axis_tvalid && m_ready()) n_push++;
      @(negedge aclk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL b2b_vec t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
      end
      if (phase == 1) begin
        n_hold++;
        total++;
        if ({fifo_level, dac_valid} !== {6'd10, 1'b1}) begin
          bad++; $display("[TB] FAIL b2b_level10: got level=%0d valid=%b expected level=10 valid=1", fifo_level, dac_valid);
        end
      end
    end
    total++;
    if (n_hold != 10) begin
      bad++; $display("[TB] FAIL b2b_reached: got %0d expected 10", n_hold);
    end
  endtask

  task automatic test_disable_mid_run();
    cfg_enable = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge aclk);
    cfg_enable = 1'b1; cfg_format = 2'($urandom);
    for (int c = 0; c < 30; c++) begin
      s_axis_tvalid = 1'b1;
      drive_word(14'($urandom), 14'($urandom));
      @(negedge aclk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL dis_vec t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
      end
    end
    cfg_enable = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge aclk);
    total++;
    if ({fifo_level, s_axis_tready, dac_rst, dac_valid} !== {6'd0, 3'b010}) begin
      bad++; $display("[TB] FAIL dis_ctrl: got %h expected %h", {fifo_level, s_axis_tready, dac_rst, dac_valid}, {6'd0, 3'b010});
    end
    total++;
    if ({dac_dat, underrun_cnt} !== {m_idle(m_fmt), 16'(e_under)}) begin
      bad++; $display("[TB] FAIL dis_dat: got %h expected %h", {dac_dat, underrun_cnt}, {m_idle(m_fmt), 16'(e_under)});
    end
    cfg_enable = 1'b1;
    @(negedge aclk);
    total++;
    if ({fifo_level, s_axis_tready, dac_rst, dac_valid} !== {6'd0, 3'b100}) begin
      bad++; $display("[TB] FAIL reen_ctrl: got %h expected %h", {fifo_level, s_axis_tready, dac_rst, dac_valid}, {6'd0, 3'b100});
    end
  endtask

  task automatic test_random();
    int prob = 60;
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) prob = (c % 150 == 0) ? 30 : ((c % 100 == 0) ? 95 : 60);
      s_axis_tvalid = ($urandom_range(99) < prob);
      drive_word(14'($urandom), 14'($urandom));
      cfg_format = 2'($urandom);
      if ($urandom_range(99) < 5) cfg_hold_last = ~cfg_hold_last;
      cfg_enable = ($urandom_range(99) >= 2);
      @(negedge aclk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL rand_vec t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full();
    int full_cycles = 0;
    int trig2 = 0;
    aresetn = 1'b0; cfg_enable = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1; cfg_enable = 1'b1; cfg_format = 2'($urandom); s_axis_tvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      drive_word(14'($urandom), 14'($urandom));
      @(negedge aclk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL full_main_vec t=%0t: got %h expected %h", $time, dut_vec(), exp_vec());
      end
      if (d2_trig === 1'b1) trig2++;
      if (d2_level === 6'd32) begin
        full_cycles++;
        total++;
        if (d2_tready !== 1'b0) begin
          bad++; $display("[TB] FAIL full_tready: got %b expected 0", d2_tready);
        end
      end
    end
    total++;
    if (full_cycles != 2) begin
      bad++; $display("[TB] FAIL full_cycles: got %0d expected 2", full_cycles);
    end
    total++;
    if (trig2 != 1) begin
      bad++; $display("[TB] FAIL full_trigger: got %0d expected 1", trig2);
    end
    total++;
    if ({d2_level, d2_valid, d2_tready} !== {6'd31, 2'b11}) begin
      bad++; $display("[TB] FAIL full_steady: got %h expected %h", {d2_level, d2_valid, d2_tready}, {6'd31, 2'b11});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_prefill_run();
    test_hold_last();
    test_formats();
    test_back_to_back();
    test_disable_mid_run();
    test_random();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
